// File: rtl/lc3_control_fsm_if.sv
// Control/handshake bundle between the LC3 sequencer and the datapath it steers.
// The sequencer uses the master modport; the datapath/memory side uses slave.
interface lc3_control_fsm_if;
  logic [15:0] ir;
  logic [15:0] wb_data;
  logic        mem_ready;

  logic        rd_le;
  logic        reg_control;
  logic        ld_mar;
  logic        ld_mdr;
  logic        ld_ir;
  logic        ld_pc;
  logic        mar_sel;
  logic        pc_sel;
  logic [1:0]  alu_op;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  cc;
  logic        halted;
  logic        bus_error;

  modport master (
    input  ir, wb_data, mem_ready,
    output rd_le, reg_control, ld_mar, ld_mdr, ld_ir, ld_pc, mar_sel, pc_sel,
           alu_op, mem_en, mem_we, cc, halted, bus_error
  );

  modport slave (
    output ir, wb_data, mem_ready,
    input  rd_le, reg_control, ld_mar, ld_mdr, ld_ir, ld_pc, mar_sel, pc_sel,
           alu_op, mem_en, mem_we, cc, halted, bus_error
  );
endinterface

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC3 instruction sequencer: fetch/decode/execute/memory/writeback
// control strobes, N/Z/P condition codes, branch resolution and memory timeout.
module lc3_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lc3_control_fsm_if.master     bus
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // Counter value seen during the last permitted wait cycle.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, FETCH_MEM, LOAD_IR, DECODE, EXEC, MEM_ADDR, MEM_ACCESS, WRITEBACK, HALT
  } state_e;

  state_e      state, next_state;
  logic [7:0]  wait_cnt;
  logic [2:0]  cc_q;
  logic        bus_error_q;
  logic        cnt_inc;
  logic        err_set;
  logic [3:0]  opcode;
  logic [1:0]  alu_dec;
  logic        is_store;
  logic        unused_ir_bits;

  assign opcode         = bus.ir[15:12];
  assign is_store       = (opcode == OP_ST) || (opcode == OP_STR);
  assign unused_ir_bits = ^bus.ir[8:0];

  always_comb begin
    case (opcode)
      OP_ADD:  alu_dec = 2'b00;
      OP_AND:  alu_dec = 2'b01;
      OP_NOT:  alu_dec = 2'b10;
      default: alu_dec = 2'b11;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state      = state;
    cnt_inc         = 1'b0;
    err_set         = 1'b0;
    bus.rd_le       = 1'b0;
    bus.reg_control = 1'b0;
    bus.ld_mar      = 1'b0;
    bus.ld_mdr      = 1'b0;
    bus.ld_ir       = 1'b0;
    bus.ld_pc       = 1'b0;
    bus.mar_sel     = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.alu_op      = 2'b00;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;

    // NOTE: strobes are qualified by rst_n so they drop the instant reset is
    // asserted, not at the next edge; the state register alone cannot do that.
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.ld_mar = 1'b1;
          bus.ld_pc  = 1'b1;
          next_state = FETCH_MEM;
        end

        FETCH_MEM, MEM_ACCESS: begin
          bus.mem_en = 1'b1;
          bus.mem_we = (state == MEM_ACCESS) && is_store;
          if (bus.mem_ready) begin
            if (state == FETCH_MEM) begin
              bus.ld_mdr = 1'b1;
              next_state = LOAD_IR;
            end else if (is_store) begin
              next_state = FETCH;
            end else begin
              bus.ld_mdr = 1'b1;
              next_state = WRITEBACK;
            end
          end else begin
            cnt_inc = 1'b1;
            if (wait_cnt == LAST_WAIT) begin
              err_set    = 1'b1;
              next_state = HALT;
            end
          end
        end

        LOAD_IR: begin
          bus.ld_ir  = 1'b1;
          next_state = DECODE;
        end

        DECODE: begin
          bus.alu_op = alu_dec;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_BR, OP_JMP: next_state = EXEC;
            OP_LD, OP_ST, OP_LDR, OP_STR:                  next_state = MEM_ADDR;
            OP_TRAP:                                       next_state = HALT;
            default:                                       next_state = FETCH;
          endcase
        end

        EXEC: begin
          // ALU op stays on so Y is valid for the register/PC load at the edge.
          bus.alu_op = alu_dec;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: bus.rd_le = 1'b1;
            OP_BR: begin
              if ((bus.ir[11:9] & cc_q) != 3'b000) begin
                bus.ld_pc  = 1'b1;
                bus.pc_sel = 1'b1;
              end
            end
            OP_JMP: begin
              bus.ld_pc  = 1'b1;
              bus.pc_sel = 1'b1;
            end
            default: ;
          endcase
          next_state = FETCH;
        end

        MEM_ADDR: begin
          bus.ld_mar  = 1'b1;
          bus.mar_sel = 1'b1;
          bus.alu_op  = 2'b11;
          next_state  = MEM_ACCESS;
        end

        WRITEBACK: begin
          bus.rd_le       = 1'b1;
          bus.reg_control = 1'b1;
          next_state      = FETCH;
        end

        HALT:    ;
        default: next_state = FETCH;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      wait_cnt    <= 8'd0;
      cc_q        <= 3'b010;
      bus_error_q <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state &&
          (next_state == FETCH_MEM || next_state == MEM_ACCESS))
        wait_cnt <= 8'd0;
      else if (cnt_inc)
        wait_cnt <= wait_cnt + 8'd1;

      if (bus.rd_le) begin
        if (bus.wb_data[15])            cc_q <= 3'b100;
        else if (bus.wb_data == 16'h0)  cc_q <= 3'b010;
        else                            cc_q <= 3'b001;
      end

      if (err_set)
        bus_error_q <= 1'b1;
    end
  end

  assign bus.cc        = cc_q;
  assign bus.bus_error = bus_error_q;
  assign bus.halted    = (state == HALT);

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Self-checking bench for lc3_control_fsm: per-cycle vector table plus
// directed sequences for memory waits, timeout and asynchronous reset.
module tb_lc3_control_fsm;

  logic clk;
  logic rst_n;

  lc3_control_fsm_if bus ();
  lc3_control_fsm_if tbus ();

  lc3_control_fsm #(.MEM_TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  lc3_control_fsm #(.MEM_TIMEOUT(4)) dut_t (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe word: {rd_le, reg_control, ld_mar, ld_mdr, ld_ir, ld_pc,
  //               mar_sel, pc_sel, alu_op[1:0], mem_en, mem_we}
  localparam logic [11:0] RD   = 12'h800;
  localparam logic [11:0] RC   = 12'h400;
  localparam logic [11:0] LMAR = 12'h200;
  localparam logic [11:0] LMDR = 12'h100;
  localparam logic [11:0] LIR  = 12'h080;
  localparam logic [11:0] LPC  = 12'h040;
  localparam logic [11:0] MSEL = 12'h020;
  localparam logic [11:0] PSEL = 12'h010;
  localparam logic [11:0] A01  = 12'h004;
  localparam logic [11:0] A10  = 12'h008;
  localparam logic [11:0] A11  = 12'h00C;
  localparam logic [11:0] MEN  = 12'h002;
  localparam logic [11:0] MWE  = 12'h001;
  localparam logic [11:0] F    = LMAR | LPC;
  localparam logic [11:0] FM   = MEN | LMDR;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [15:0] wb;
    logic        rdy;
    logic        rst;
    logic [11:0] strobes;
    logic [2:0]  cc;
    logic [1:0]  status;   // {halted, bus_error}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(string name, logic [15:0] ir, logic [15:0] wb,
                             logic rdy, logic rst, logic [11:0] s,
                             logic [2:0] cc, logic [1:0] st);
    vec_t r;
    r.name = name; r.ir = ir; r.wb = wb; r.rdy = rdy; r.rst = rst;
    r.strobes = s; r.cc = cc; r.status = st;
    return r;
  endfunction

  function automatic logic [11:0] strobes_main();
    return {bus.rd_le, bus.reg_control, bus.ld_mar, bus.ld_mdr, bus.ld_ir,
            bus.ld_pc, bus.mar_sel, bus.pc_sel, bus.alu_op, bus.mem_en, bus.mem_we};
  endfunction

  function automatic logic [11:0] strobes_t();
    return {tbus.rd_le, tbus.reg_control, tbus.ld_mar, tbus.ld_mdr, tbus.ld_ir,
            tbus.ld_pc, tbus.mar_sel, tbus.pc_sel, tbus.alu_op, tbus.mem_en, tbus.mem_we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, return at the negedge.
  task automatic tick(input logic [15:0] ir_v, input logic [15:0] wb_v,
                      input logic rdy_v, input logic t_rdy_v);
    @(posedge clk);
    #1;
    bus.ir = ir_v; bus.wb_data = wb_v; bus.mem_ready = rdy_v;
    tbus.mem_ready = t_rdy_v;
    @(negedge clk);
  endtask

  // Pulse reset; returns at the negedge of cycle 1 (FETCH) after release.
  task automatic do_reset(input logic [15:0] ir_v, input logic [15:0] wb_v);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.ir = ir_v; bus.wb_data = wb_v; bus.mem_ready = 1'b0;
    tbus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int men_cnt;
    logic rdy;

    rst_n = 1'b0;
    bus.ir = 16'h0; bus.wb_data = 16'h0; bus.mem_ready = 1'b0;
    tbus.ir = 16'h1000; tbus.wb_data = 16'h0; tbus.mem_ready = 1'b0;

    vecs.push_back(v("reset",      16'h0000, 16'h0000, 1'b0, 1'b0, 12'h000,     3'b010, 2'b00));
    // BRz taken with CC=010
    vecs.push_back(v("brz_fetch",  16'h0400, 16'h0000, 1'b0, 1'b1, F,           3'b010, 2'b00));
    vecs.push_back(v("brz_fmem",   16'h0400, 16'h0000, 1'b1, 1'b1, FM,          3'b010, 2'b00));
    vecs.push_back(v("brz_ldir",   16'h0400, 16'h0000, 1'b1, 1'b1, LIR,         3'b010, 2'b00));
    vecs.push_back(v("brz_dec",    16'h0400, 16'h0000, 1'b1, 1'b1, A11,         3'b010, 2'b00));
    vecs.push_back(v("brz_exec",   16'h0400, 16'h0000, 1'b1, 1'b1, LPC|PSEL|A11, 3'b010, 2'b00));
    // BRn not taken with CC=010
    vecs.push_back(v("brn_fetch",  16'h0800, 16'h0000, 1'b0, 1'b1, F,           3'b010, 2'b00));
    vecs.push_back(v("brn_fmem",   16'h0800, 16'h0000, 1'b1, 1'b1, FM,          3'b010, 2'b00));
    vecs.push_back(v("brn_ldir",   16'h0800, 16'h0000, 1'b1, 1'b1, LIR,         3'b010, 2'b00));
    vecs.push_back(v("brn_dec",    16'h0800, 16'h0000, 1'b1, 1'b1, A11,         3'b010, 2'b00));
    vecs.push_back(v("brn_exec",   16'h0800, 16'h0000, 1'b1, 1'b1, A11,         3'b010, 2'b00));
    // ADD, WB=FFFF -> N
    vecs.push_back(v("add_fetch",  16'h1000, 16'hFFFF, 1'b0, 1'b1, F,           3'b010, 2'b00));
    vecs.push_back(v("add_fmem",   16'h1000, 16'hFFFF, 1'b1, 1'b1, FM,          3'b010, 2'b00));
    vecs.push_back(v("add_ldir",   16'h1000, 16'hFFFF, 1'b1, 1'b1, LIR,         3'b010, 2'b00));
    vecs.push_back(v("add_dec",    16'h1000, 16'hFFFF, 1'b1, 1'b1, 12'h000,     3'b010, 2'b00));
    vecs.push_back(v("add_exec",   16'h1000, 16'hFFFF, 1'b1, 1'b1, RD,          3'b010, 2'b00));
    // AND with one fetch wait, WB=0005 -> P
    vecs.push_back(v("and_fetch",  16'h5000, 16'h0005, 1'b0, 1'b1, F,           3'b100, 2'b00));
    vecs.push_back(v("and_wait",   16'h5000, 16'h0005, 1'b0, 1'b1, MEN,         3'b100, 2'b00));
    vecs.push_back(v("and_fmem",   16'h5000, 16'h0005, 1'b1, 1'b1, FM,          3'b100, 2'b00));
    vecs.push_back(v("and_ldir",   16'h5000, 16'h0005, 1'b1, 1'b1, LIR,         3'b100, 2'b00));
    vecs.push_back(v("and_dec",    16'h5000, 16'h0005, 1'b1, 1'b1, A01,         3'b100, 2'b00));
    vecs.push_back(v("and_exec",   16'h5000, 16'h0005, 1'b1, 1'b1, RD|A01,      3'b100, 2'b00));
    // STR, WB=0 must not touch CC
    vecs.push_back(v("str_fetch",  16'h7000, 16'h0000, 1'b0, 1'b1, F,           3'b001, 2'b00));
    vecs.push_back(v("str_fmem",   16'h7000, 16'h0000, 1'b1, 1'b1, FM,          3'b001, 2'b00));
    vecs.push_back(v("str_ldir",   16'h7000, 16'h0000, 1'b1, 1'b1, LIR,         3'b001, 2'b00));
    vecs.push_back(v("str_dec",    16'h7000, 16'h0000, 1'b1, 1'b1, A11,         3'b001, 2'b00));
    vecs.push_back(v("str_maddr",  16'h7000, 16'h0000, 1'b1, 1'b1, LMAR|MSEL|A11, 3'b001, 2'b00));
    vecs.push_back(v("str_macc",   16'h7000, 16'h0000, 1'b1, 1'b1, MEN|MWE,     3'b001, 2'b00));
    // NOT, WB=0 -> Z
    vecs.push_back(v("not_fetch",  16'h9000, 16'h0000, 1'b0, 1'b1, F,           3'b001, 2'b00));
    vecs.push_back(v("not_fmem",   16'h9000, 16'h0000, 1'b1, 1'b1, FM,          3'b001, 2'b00));
    vecs.push_back(v("not_ldir",   16'h9000, 16'h0000, 1'b1, 1'b1, LIR,         3'b001, 2'b00));
    vecs.push_back(v("not_dec",    16'h9000, 16'h0000, 1'b1, 1'b1, A10,         3'b001, 2'b00));
    vecs.push_back(v("not_exec",   16'h9000, 16'h0000, 1'b1, 1'b1, RD|A10,      3'b001, 2'b00));
    // JMP
    vecs.push_back(v("jmp_fetch",  16'hC000, 16'h0000, 1'b0, 1'b1, F,           3'b010, 2'b00));
    vecs.push_back(v("jmp_fmem",   16'hC000, 16'h0000, 1'b1, 1'b1, FM,          3'b010, 2'b00));
    vecs.push_back(v("jmp_ldir",   16'hC000, 16'h0000, 1'b1, 1'b1, LIR,         3'b010, 2'b00));
    vecs.push_back(v("jmp_dec",    16'hC000, 16'h0000, 1'b1, 1'b1, A11,         3'b010, 2'b00));
    vecs.push_back(v("jmp_exec",   16'hC000, 16'h0000, 1'b1, 1'b1, LPC|PSEL|A11, 3'b010, 2'b00));
    // LEA, WB=1234 -> P
    vecs.push_back(v("lea_fetch",  16'hE000, 16'h1234, 1'b0, 1'b1, F,           3'b010, 2'b00));
    vecs.push_back(v("lea_fmem",   16'hE000, 16'h1234, 1'b1, 1'b1, FM,          3'b010, 2'b00));
    vecs.push_back(v("lea_ldir",   16'hE000, 16'h1234, 1'b1, 1'b1, LIR,         3'b010, 2'b00));
    vecs.push_back(v("lea_dec",    16'hE000, 16'h1234, 1'b1, 1'b1, A11,         3'b010, 2'b00));
    vecs.push_back(v("lea_exec",   16'hE000, 16'h1234, 1'b1, 1'b1, RD|A11,      3'b010, 2'b00));
    // Reserved opcode acts as NOP: 4 cycles back to FETCH
    vecs.push_back(v("nop_fetch",  16'hD000, 16'h0000, 1'b0, 1'b1, F,           3'b001, 2'b00));
    vecs.push_back(v("nop_fmem",   16'hD000, 16'h0000, 1'b1, 1'b1, FM,          3'b001, 2'b00));
    vecs.push_back(v("nop_ldir",   16'hD000, 16'h0000, 1'b1, 1'b1, LIR,         3'b001, 2'b00));
    vecs.push_back(v("nop_dec",    16'hD000, 16'h0000, 1'b1, 1'b1, A11,         3'b001, 2'b00));
    // TRAP -> HALT, sticky
    vecs.push_back(v("trap_fetch", 16'hF025, 16'h0000, 1'b0, 1'b1, F,           3'b001, 2'b00));
    vecs.push_back(v("trap_fmem",  16'hF025, 16'h0000, 1'b1, 1'b1, FM,          3'b001, 2'b00));
    vecs.push_back(v("trap_ldir",  16'hF025, 16'h0000, 1'b1, 1'b1, LIR,         3'b001, 2'b00));
    vecs.push_back(v("trap_dec",   16'hF025, 16'h0000, 1'b1, 1'b1, A11,         3'b001, 2'b00));
    vecs.push_back(v("halt_0",     16'hF025, 16'h0000, 1'b0, 1'b1, 12'h000,     3'b001, 2'b10));
    vecs.push_back(v("halt_1",     16'h1000, 16'hFFFF, 1'b1, 1'b1, 12'h000,     3'b001, 2'b10));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst;
      bus.ir = vecs[i].ir; bus.wb_data = vecs[i].wb; bus.mem_ready = vecs[i].rdy;
      @(negedge clk);
      check({vecs[i].name, "_strobes"}, 32'(strobes_main()), 32'(vecs[i].strobes));
      check({vecs[i].name, "_cc"},      32'(bus.cc),         32'(vecs[i].cc));
      check({vecs[i].name, "_status"},  32'({bus.halted, bus.bus_error}), 32'(vecs[i].status));
    end

    // LD with MEM_READY delayed 3 cycles, preceded by ADD giving CC=001
    do_reset(16'h1000, 16'h0001);
    for (int c = 2; c <= 5; c++) tick(16'h1000, 16'h0001, 1'b1, 1'b0);
    check("pre_add_rd_le", 32'(bus.rd_le), 32'd1);
    tick(16'h2000, 16'h0000, 1'b1, 1'b0);
    check("ld_c1_cc", 32'(bus.cc), 32'b001);
    check("ld_c1_strobes", 32'(strobes_main()), 32'(F));
    men_cnt = 0;
    for (int c = 2; c <= 11; c++) begin
      rdy = !(c == 6 || c == 7 || c == 8);
      tick(16'h2000, 16'h0000, rdy, 1'b0);
      if (c >= 5 && bus.mem_en) men_cnt++;
      if (bus.mem_we) check($sformatf("ld_c%0d_mem_we", c), 32'(bus.mem_we), 32'd0);
      if (c == 9)  check("ld_c9_ld_mdr", 32'({bus.ld_mdr, bus.rd_le}), 32'b10);
      if (c == 10) check("ld_c10_wb", 32'({bus.rd_le, bus.reg_control}), 32'b11);
      if (c == 11) begin
        check("ld_c11_cc", 32'(bus.cc), 32'b010);
        check("ld_c11_strobes", 32'(strobes_main()), 32'(F));
      end
    end
    check("ld_mem_en_cycles", 32'(men_cnt), 32'd4);

    // Timeout on the MEM_TIMEOUT=4 instance
    do_reset(16'h1000, 16'h0000);
    check("to_c1_strobes", 32'(strobes_t()), 32'(F));
    for (int c = 2; c <= 5; c++) tick(16'h1000, 16'h0000, 1'b1, 1'b0);
    check("to_c5_pending", 32'({tbus.mem_en, tbus.halted, tbus.bus_error}), 32'b100);
    tick(16'h1000, 16'h0000, 1'b1, 1'b0);
    check("to_c6_status", 32'({tbus.halted, tbus.bus_error}), 32'b11);
    check("to_c6_strobes", 32'(strobes_t()), 32'd0);
    for (int c = 7; c <= 9; c++) begin
      tick(16'h1000, 16'h0000, 1'b1, 1'b1);
      check($sformatf("to_c%0d_strobes", c), 32'(strobes_t()), 32'd0);
    end
    check("to_sticky_status", 32'({tbus.halted, tbus.bus_error}), 32'b11);

    // MEM_READY in the timeout cycle wins
    do_reset(16'h1000, 16'h0000);
    for (int c = 2; c <= 4; c++) tick(16'h1000, 16'h0000, 1'b1, 1'b0);
    tick(16'h1000, 16'h0000, 1'b1, 1'b1);
    check("tw_c5_strobes", 32'(strobes_t()), 32'(FM));
    tick(16'h1000, 16'h0000, 1'b1, 1'b0);
    check("tw_c6_strobes", 32'(strobes_t()), 32'(LIR));
    check("tw_c6_status", 32'({tbus.halted, tbus.bus_error}), 32'b00);

    // Reset asserted during MEM_ACCESS of ST, CC previously 100
    do_reset(16'h1000, 16'hFFFF);
    for (int c = 2; c <= 5; c++) tick(16'h1000, 16'hFFFF, 1'b1, 1'b0);
    tick(16'h3000, 16'h0000, 1'b1, 1'b0);
    for (int c = 2; c <= 5; c++) tick(16'h3000, 16'h0000, 1'b1, 1'b0);
    tick(16'h3000, 16'h0000, 1'b0, 1'b0);
    check("st_macc_strobes", 32'(strobes_main()), 32'(MEN|MWE));
    check("st_macc_cc", 32'(bus.cc), 32'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check("st_rst_mem", 32'({bus.mem_en, bus.mem_we}), 32'b00);
    check("st_rst_strobes", 32'(strobes_main()), 32'd0);
    check("st_rst_cc", 32'(bus.cc), 32'b010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("st_restart_fetch", 32'(strobes_main()), 32'(F));
    tick(16'h3000, 16'h0000, 1'b1, 1'b0);
    check("st_restart_fmem", 32'(strobes_main()), 32'(FM));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
